// File: rtl/regbank_operand_fetch_if.sv
// Signal bundle between the operand-fetch block and its decode, regfile,
// execute and writeback neighbours.
interface regbank_operand_fetch_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CNTW = 16
);
    logic            id_valid;
    logic            id_ready;
    logic [AW-1:0]   id_sr1;
    logic [AW-1:0]   id_sr2;
    logic [AW-1:0]   id_dr;
    logic            id_wen;
    logic [AW-1:0]   sr1;
    logic [AW-1:0]   sr2;
    logic [DW-1:0]   rdData1;
    logic [DW-1:0]   rdData2;
    logic            write;
    logic [AW-1:0]   dr;
    logic [DW-1:0]   wrData;
    logic            ex_valid;
    logic            ex_ready;
    logic [DW-1:0]   ex_op1;
    logic [DW-1:0]   ex_op2;
    logic [AW-1:0]   ex_dr;
    logic            ex_wen;
    logic            flush;
    logic            wb_valid;
    logic [AW-1:0]   wb_dr;
    logic [DW-1:0]   wb_data;
    logic [NREG-1:0] busy_mask;
    logic            wb_orphan;
    logic [CNTW-1:0] stall_cnt;

    // master: the operand-fetch block; slave: the surrounding pipeline/regfile
    modport master (
        input  id_valid, id_sr1, id_sr2, id_dr, id_wen, rdData1, rdData2,
               ex_ready, flush, wb_valid, wb_dr, wb_data,
        output id_ready, sr1, sr2, write, dr, wrData, ex_valid, ex_op1, ex_op2,
               ex_dr, ex_wen, busy_mask, wb_orphan, stall_cnt
    );
    modport slave (
        output id_valid, id_sr1, id_sr2, id_dr, id_wen, rdData1, rdData2,
               ex_ready, flush, wb_valid, wb_dr, wb_data,
        input  id_ready, sr1, sr2, write, dr, wrData, ex_valid, ex_op1, ex_op2,
               ex_dr, ex_wen, busy_mask, wb_orphan, stall_cnt
    );
endinterface

// File: rtl/regbank_operand_fetch.sv
// Operand fetch for the 5-stage pipeline: regfile reads with writeback bypass,
// pending-write scoreboard with RAW/WAW stall, and a one-entry execute register.
module regbank_operand_fetch #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic clk,
    input  logic reset,
    regbank_operand_fetch_if.master bus
);
    logic [DW-1:0]   op1, op2;
    logic            byp1, byp2, bypd;
    logic            raw1, raw2, waw;
    logic            ready, accept, new_wen;
    logic [NREG-1:0] busy_nxt;

    always_comb begin
        bus.sr1    = bus.id_sr1;
        bus.sr2    = bus.id_sr2;
        bus.write  = bus.wb_valid && (bus.wb_dr != '0);
        bus.dr     = bus.wb_dr;
        bus.wrData = bus.wb_data;

        byp1 = bus.wb_valid && (bus.wb_dr == bus.id_sr1);
        byp2 = bus.wb_valid && (bus.wb_dr == bus.id_sr2);
        bypd = bus.wb_valid && (bus.wb_dr == bus.id_dr);

        op1 = (bus.id_sr1 == '0) ? '0 : (byp1 ? bus.wb_data : bus.rdData1);
        op2 = (bus.id_sr2 == '0) ? '0 : (byp2 ? bus.wb_data : bus.rdData2);

        raw1 = (bus.id_sr1 != '0) && bus.busy_mask[bus.id_sr1] && !byp1;
        raw2 = (bus.id_sr2 != '0) && bus.busy_mask[bus.id_sr2] && !byp2;
        waw  = bus.id_wen && (bus.id_dr != '0) && bus.busy_mask[bus.id_dr] && !bypd;

        ready        = !raw1 && !raw2 && !waw && (!bus.ex_valid || bus.ex_ready) && !bus.flush;
        bus.id_ready = ready;
        accept       = bus.id_valid && ready;
        new_wen      = bus.id_wen && (bus.id_dr != '0);

        // Clears are applied before the set so a new owner of the same register wins.
        busy_nxt = bus.busy_mask;
        if (bus.wb_valid)
            busy_nxt[bus.wb_dr] = 1'b0;
        if (bus.flush && bus.ex_valid && bus.ex_wen)
            busy_nxt[bus.ex_dr] = 1'b0;
        if (accept && new_wen)
            busy_nxt[bus.id_dr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ex_valid  <= 1'b0;
            bus.ex_op1    <= '0;
            bus.ex_op2    <= '0;
            bus.ex_dr     <= '0;
            bus.ex_wen    <= 1'b0;
            bus.busy_mask <= '0;
            bus.wb_orphan <= 1'b0;
            bus.stall_cnt <= '0;
        end else begin
            if (bus.flush) begin
                bus.ex_valid <= 1'b0;
            end else if (accept) begin
                bus.ex_valid <= 1'b1;
                bus.ex_op1   <= op1;
                bus.ex_op2   <= op2;
                bus.ex_dr    <= bus.id_dr;
                bus.ex_wen   <= new_wen;
            end else if (bus.ex_ready) begin
                bus.ex_valid <= 1'b0;
            end
            bus.busy_mask <= busy_nxt;
            bus.wb_orphan <= bus.wb_valid && (bus.wb_dr != '0) && !bus.busy_mask[bus.wb_dr];
            if (bus.id_valid && !ready && (bus.stall_cnt != '1))
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_regbank_operand_fetch.sv
// Directed bench for regbank_operand_fetch: issue, hazard stall, bypass, R0
// masking, execute backpressure, flush, orphan writeback and async reset.
module tb_regbank_operand_fetch;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [31:0] rf [32];

    regbank_operand_fetch_if #(.NREG(32), .AW(5), .DW(32), .CNTW(16)) bus ();

    regbank_operand_fetch #(.NREG(32), .AW(5), .DW(32), .CNTW(16)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.rdData1 = rf[bus.sr1];
        bus.rdData2 = rf[bus.sr2];
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic w);
        bus.id_valid = 1'b1;
        bus.id_sr1   = s1;
        bus.id_sr2   = s2;
        bus.id_dr    = d;
        bus.id_wen   = w;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'hFFFF_FFFF;
        rf[3] = 32'h11;
        rf[4] = 32'h22;
        bus.id_valid = 0; bus.id_sr1 = 0; bus.id_sr2 = 0; bus.id_dr = 0; bus.id_wen = 0;
        bus.ex_ready = 1; bus.flush = 0; bus.wb_valid = 0; bus.wb_dr = 0; bus.wb_data = 0;
        #12;
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_busy", bus.busy_mask, 0);
        check("rst_stall", bus.stall_cnt, 0);
        check("rst_orphan", bus.wb_orphan, 0);
        reset = 1'b1;
        tick();

        // basic issue
        issue(3, 4, 0, 0);
        #1;
        check("t1_ready", bus.id_ready, 1);
        check("t1_sr1", bus.sr1, 3);
        tick();
        check("t1_ex_valid", bus.ex_valid, 1);
        check("t1_op1", bus.ex_op1, 32'h11);
        check("t1_op2", bus.ex_op2, 32'h22);

        // RAW stall then same-cycle bypass release
        issue(1, 2, 5, 1);
        tick();
        check("t2_ex_dr", bus.ex_dr, 5);
        check("t2_ex_wen", bus.ex_wen, 1);
        check("t2_busy", bus.busy_mask, 32'h20);
        issue(5, 0, 0, 0);
        #1;
        check("t2_stall_ready", bus.id_ready, 0);
        tick();
        tick();
        check("t2_stall_cnt", bus.stall_cnt, 2);
        check("t2_ex_drained", bus.ex_valid, 0);
        bus.wb_valid = 1; bus.wb_dr = 5; bus.wb_data = 32'hABCD;
        #1;
        check("t2_byp_ready", bus.id_ready, 1);
        check("t2_write", bus.write, 1);
        check("t2_dr", bus.dr, 5);
        check("t2_wrdata", bus.wrData, 32'hABCD);
        tick();
        bus.wb_valid = 0;
        check("t2_op1_byp", bus.ex_op1, 32'hABCD);
        check("t2_busy_clr", bus.busy_mask, 0);
        check("t2_stall_hold", bus.stall_cnt, 2);
        check("t2_no_orphan", bus.wb_orphan, 0);

        // R0 masking
        issue(0, 4, 0, 1);
        tick();
        check("t3_op1_r0", bus.ex_op1, 0);
        check("t3_op2", bus.ex_op2, 32'h22);
        check("t3_ex_wen_r0", bus.ex_wen, 0);
        check("t3_busy_r0", bus.busy_mask, 0);
        bus.id_valid = 0;
        bus.wb_valid = 1; bus.wb_dr = 0; bus.wb_data = 32'h1234;
        #1;
        check("t3_write_r0", bus.write, 0);
        tick();
        bus.wb_valid = 0;
        check("t3_orphan_r0", bus.wb_orphan, 0);

        // execute backpressure
        bus.ex_ready = 0;
        issue(6, 7, 8, 1);
        tick();
        check("t4_op1", bus.ex_op1, 32'h1006);
        check("t4_busy", bus.busy_mask, 32'h100);
        issue(9, 10, 11, 1);
        for (int i = 0; i < 3; i++) begin
            check("t4_bp_ready", bus.id_ready, 0);
            tick();
            check("t4_hold_op1", bus.ex_op1, 32'h1006);
            check("t4_hold_dr", bus.ex_dr, 8);
        end
        check("t4_stall_cnt", bus.stall_cnt, 5);
        bus.ex_ready = 1;
        #1;
        check("t4_rel_ready", bus.id_ready, 1);
        tick();
        check("t4_rel_op1", bus.ex_op1, 32'h1009);
        check("t4_rel_op2", bus.ex_op2, 32'h100A);
        check("t4_rel_dr", bus.ex_dr, 11);
        check("t4_rel_busy", bus.busy_mask, 32'h900);

        // flush and orphan writeback
        issue(1, 2, 7, 1);
        tick();
        check("t5_busy7", bus.busy_mask, 32'h980);
        bus.id_valid = 0;
        bus.flush = 1;
        #1;
        check("t5_flush_ready", bus.id_ready, 0);
        tick();
        bus.flush = 0;
        check("t5_flush_valid", bus.ex_valid, 0);
        check("t5_flush_busy", bus.busy_mask, 32'h900);
        bus.wb_valid = 1; bus.wb_dr = 9; bus.wb_data = 32'h5;
        tick();
        bus.wb_valid = 0;
        check("t5_orphan", bus.wb_orphan, 1);
        check("t5_orphan_busy", bus.busy_mask, 32'h900);
        tick();
        check("t5_orphan_end", bus.wb_orphan, 0);

        // set wins over clear on the same register
        issue(0, 0, 11, 1);
        bus.wb_valid = 1; bus.wb_dr = 11; bus.wb_data = 32'h7;
        #1;
        check("t5_waw_byp_ready", bus.id_ready, 1);
        tick();
        check("t5_set_wins", bus.busy_mask, 32'h900);
        bus.id_valid = 0;
        bus.wb_dr = 8;
        tick();
        check("t5_clr8", bus.busy_mask, 32'h800);

        // async reset mid-stall
        issue(0, 0, 5, 1);
        bus.wb_dr = 11;
        tick();
        bus.wb_valid = 0;
        issue(0, 0, 7, 1);
        tick();
        check("t6_busy", bus.busy_mask, 32'hA0);
        issue(5, 0, 0, 0);
        tick();
        check("t6_stall_cnt", bus.stall_cnt, 6);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_valid", bus.ex_valid, 0);
        check("t6_rst_busy", bus.busy_mask, 0);
        check("t6_rst_stall", bus.stall_cnt, 0);
        check("t6_rst_op1", bus.ex_op1, 0);
        check("t6_rst_dr", bus.ex_dr, 0);
        check("t6_rst_wen", bus.ex_wen, 0);
        check("t6_rst_orphan", bus.wb_orphan, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
